// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings and defaults for the RV32 pipeline hazard unit.
package riscv_pkg;

   localparam int unsigned REG_ADDR_W_DFLT = 5;
   localparam int unsigned MC_CNT_W        = 4;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit signal bundle; the pipeline is the master.
interface hazard_ctrl_unit_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
);
   logic                  reg_write_m;
   logic                  reg_write_w;
   logic [REG_ADDR_W-1:0] rd_e;
   logic [REG_ADDR_W-1:0] rd_m;
   logic [REG_ADDR_W-1:0] rd_w;
   logic [REG_ADDR_W-1:0] rs1_d;
   logic [REG_ADDR_W-1:0] rs2_d;
   logic [REG_ADDR_W-1:0] rs1_e;
   logic [REG_ADDR_W-1:0] rs2_e;
   logic                  load_e;
   logic                  pc_src_e;
   logic                  mul_start_e;

   logic [1:0]            forward_a_e;
   logic [1:0]            forward_b_e;
   logic                  stall_f;
   logic                  stall_d;
   logic                  stall_e;
   logic                  flush_d;
   logic                  flush_e;
   logic                  flush_m;
   logic                  mc_busy;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output reg_write_m, reg_write_w, rd_e, rd_m, rd_w, rs1_d, rs2_d,
             rs1_e, rs2_e, load_e, pc_src_e, mul_start_e,
      input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
             flush_d, flush_e, flush_m, mc_busy, stall_cnt
   );

   modport slave (
      input  reg_write_m, reg_write_w, rd_e, rd_m, rd_w, rs1_d, rs2_d,
             rs1_e, rs2_e, load_e, pc_src_e, mul_start_e,
      output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
             flush_d, flush_e, flush_m, mc_busy, stall_cnt
   );

endinterface

// File: rtl/hazard_ctrl_unit_mc_interlock.sv
// Multi-cycle execute-op interlock: holds the op in E for MC_LAT cycles.
module mc_interlock
   import riscv_pkg::*;
#(
   parameter int unsigned MC_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic mul_start,
   input  logic pc_src,
   output logic mc_stall,
   output logic mc_busy
);

   localparam logic [MC_CNT_W-1:0] CNT_INIT = MC_CNT_W'(MC_LAT - 2);

   mc_state_t           state;
   logic [MC_CNT_W-1:0] cnt;

   // A taken branch kills the op in E, so it never starts the interlock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MC_IDLE: begin
               if (mul_start && !pc_src) begin
                  state <= MC_BUSY;
                  cnt   <= CNT_INIT;
               end
            end
            MC_BUSY: begin
               if (cnt == '0) begin
                  state <= MC_IDLE;
               end else begin
                  cnt <= cnt - MC_CNT_W'(1);
               end
            end
            default: begin
               state <= MC_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      mc_stall = 1'b0;
      if (rst) begin
         if (state == MC_IDLE) begin
            mc_stall = mul_start && !pc_src;
         end else begin
            mc_stall = (cnt != '0);
         end
      end
   end

   assign mc_busy = (state == MC_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage RV32 pipeline: forwarding, load-use and
// multi-cycle stalls, branch flushes and a saturating stall counter.
module hazard_ctrl_unit
   import riscv_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT,
   parameter int unsigned MC_LAT     = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
   hazard_ctrl_unit_if.slave  bus
);

   logic             lw_stall;
   logic             mc_stall;
   logic             mc_busy;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt_q;

   // M-stage result is younger than W-stage, so it wins.
   function automatic logic [1:0] fwd_sel(
      input logic                  we_m,
      input logic [REG_ADDR_W-1:0] rd_m,
      input logic                  we_w,
      input logic [REG_ADDR_W-1:0] rd_w,
      input logic [REG_ADDR_W-1:0] rs
   );
      logic [1:0] sel;
      sel = FWD_REG;
      if (we_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   mc_interlock #(
      .MC_LAT (MC_LAT)
   ) u_mc_interlock (
      .clk       (clk),
      .rst       (rst),
      .mul_start (bus.mul_start_e),
      .pc_src    (bus.pc_src_e),
      .mc_stall  (mc_stall),
      .mc_busy   (mc_busy)
   );

   always_comb begin
      bus.forward_a_e = FWD_REG;
      bus.forward_b_e = FWD_REG;
      if (rst) begin
         bus.forward_a_e = fwd_sel(bus.reg_write_m, bus.rd_m, bus.reg_write_w, bus.rd_w, bus.rs1_e);
         bus.forward_b_e = fwd_sel(bus.reg_write_m, bus.rd_m, bus.reg_write_w, bus.rd_w, bus.rs2_e);
      end
   end

   always_comb begin
      lw_stall = rst && bus.load_e && (bus.rd_e != '0) &&
                 ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));
      stall    = lw_stall || mc_stall;
   end

   // A pending multi-cycle op already holds ID/EX, so no load-use bubble then.
   always_comb begin
      bus.stall_f = stall;
      bus.stall_d = stall;
      bus.stall_e = mc_stall;
      bus.flush_d = rst && bus.pc_src_e;
      bus.flush_e = (rst && bus.pc_src_e) || (lw_stall && !mc_stall);
      bus.flush_m = mc_stall;
      bus.mc_busy = mc_busy;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: vector table plus multi-cycle sequences.
module tb_hazard_ctrl_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
   hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  bus4 ();

   hazard_ctrl_unit #(.REG_ADDR_W(5), .MC_LAT(4), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   hazard_ctrl_unit #(.REG_ADDR_W(5), .MC_LAT(4), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   // Expected field: {fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy}
   typedef struct packed {
      logic        we_m;
      logic        we_w;
      logic [4:0]  rd_e;
      logic [4:0]  rd_m;
      logic [4:0]  rd_w;
      logic [4:0]  rs1_d;
      logic [4:0]  rs2_d;
      logic [4:0]  rs1_e;
      logic [4:0]  rs2_e;
      logic        load;
      logic        pc_src;
      logic [10:0] exp;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_cnt = 0;

   logic [0:7] mul_stall_pat = 8'b1110_1110;
   logic [0:7] mul_busy_pat  = 8'b0111_0111;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [10:0] outs();
      return {bus.forward_a_e, bus.forward_b_e, bus.stall_f, bus.stall_d, bus.stall_e,
              bus.flush_d, bus.flush_e, bus.flush_m, bus.mc_busy};
   endfunction

   task automatic clear_inputs();
      bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0;
      bus.rd_e = '0; bus.rd_m = '0; bus.rd_w = '0;
      bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0;
      bus.load_e = 1'b0; bus.pc_src_e = 1'b0; bus.mul_start_e = 1'b0;
   endtask

   task automatic clear_inputs4();
      bus4.reg_write_m = 1'b0; bus4.reg_write_w = 1'b0;
      bus4.rd_e = '0; bus4.rd_m = '0; bus4.rd_w = '0;
      bus4.rs1_d = '0; bus4.rs2_d = '0; bus4.rs1_e = '0; bus4.rs2_e = '0;
      bus4.load_e = 1'b0; bus4.pc_src_e = 1'b0; bus4.mul_start_e = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      //               we_m  we_w  rd_e   rd_m   rd_w   rs1_d  rs2_d  rs1_e  rs2_e  load  pcsrc  expected
      vecs[0]  = '{1'b1, 1'b1, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, {2'b10, 2'b00, 7'b0000000}};
      vecs[1]  = '{1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, {2'b01, 2'b00, 7'b0000000}};
      vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, {2'b00, 2'b00, 7'b0000000}};
      vecs[3]  = '{1'b1, 1'b1, 5'd0, 5'd3, 5'd4, 5'd0, 5'd0, 5'd4, 5'd3, 1'b0, 1'b0, {2'b01, 2'b10, 7'b0000000}};
      vecs[4]  = '{1'b0, 1'b0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, {2'b00, 2'b00, 7'b0000000}};
      vecs[5]  = '{1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, {2'b00, 2'b00, 7'b1100100}};
      vecs[6]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, {2'b00, 2'b00, 7'b0000000}};
      vecs[7]  = '{1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, {2'b00, 2'b00, 7'b1100100}};
      vecs[8]  = '{1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, {2'b00, 2'b00, 7'b0000000}};
      vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, {2'b00, 2'b00, 7'b0001100}};
      vecs[10] = '{1'b1, 1'b0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 1'b0, 1'b1, {2'b10, 2'b10, 7'b0001100}};
      vecs[11] = '{1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 5'd8, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, {2'b00, 2'b01, 7'b1100100}};

      clear_inputs();
      clear_inputs4();

      // Reset holds every output low even with hazards present on the inputs.
      bus.reg_write_m = 1'b1; bus.rd_m = 5'd5; bus.rs1_e = 5'd5;
      bus.load_e = 1'b1; bus.rd_e = 5'd7; bus.rs1_d = 5'd7;
      #2;
      check("reset_outs", 32'(outs()), 32'd0);
      check("reset_cnt", bus.stall_cnt, 32'd0);
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         bus.reg_write_m = vecs[i].we_m;  bus.reg_write_w = vecs[i].we_w;
         bus.rd_e  = vecs[i].rd_e;  bus.rd_m  = vecs[i].rd_m;  bus.rd_w  = vecs[i].rd_w;
         bus.rs1_d = vecs[i].rs1_d; bus.rs2_d = vecs[i].rs2_d;
         bus.rs1_e = vecs[i].rs1_e; bus.rs2_e = vecs[i].rs2_e;
         bus.load_e = vecs[i].load; bus.pc_src_e = vecs[i].pc_src;
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
         if (vecs[i].exp[6]) exp_cnt++;
         step();
      end
      clear_inputs();
      #1;
      check("table_cnt", bus.stall_cnt, 32'(exp_cnt));

      // Load-use lasts one cycle once the bubble replaces the load in E.
      @(negedge clk);
      bus.load_e = 1'b1; bus.rd_e = 5'd7; bus.rs2_d = 5'd7;
      #1;
      check("lu_stall", 32'(outs()), 32'(11'b00_00_1100100));
      step();
      clear_inputs();
      exp_cnt++;
      #1;
      check("lu_release", 32'(outs()), 32'd0);
      check("lu_cnt", bus.stall_cnt, 32'(exp_cnt));

      // Taken branch beats a simultaneous multi-cycle start.
      @(negedge clk);
      bus.pc_src_e = 1'b1; bus.mul_start_e = 1'b1;
      #1;
      check("br_mul", 32'(outs()), 32'(11'b00_00_0001100));
      step();
      clear_inputs();
      #1;
      check("br_mul_idle", 32'(outs()), 32'd0);

      // Two back-to-back multi-cycle ops with MulStartE held high.
      @(negedge clk);
      bus.mul_start_e = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("mul_c%0d", i + 1), 32'(outs()),
               32'({4'b0000, {3{mul_stall_pat[i]}}, 2'b00, mul_stall_pat[i], mul_busy_pat[i]}));
         if (mul_stall_pat[i]) exp_cnt++;
         if (i == 7) bus.mul_start_e = 1'b0;
         step();
      end
      #1;
      check("mul_done", 32'(outs()), 32'd0);
      check("mul_cnt", bus.stall_cnt, 32'(exp_cnt));

      // Asynchronous reset in BUSY with cnt==1 abandons the op immediately.
      @(negedge clk);
      bus.mul_start_e = 1'b1;
      step();
      bus.mul_start_e = 1'b0;
      step();
      #1;
      rst = 1'b0;
      #1;
      check("rst_busy_outs", 32'(outs()), 32'd0);
      check("rst_busy_cnt", bus.stall_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      bus.mul_start_e = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("mul_rst_c%0d", i + 1), {31'd0, bus.stall_f, bus.mc_busy},
               {31'd0, mul_stall_pat[i], mul_busy_pat[i]});
         if (mul_stall_pat[i]) exp_cnt++;
         if (i == 3) bus.mul_start_e = 1'b0;
         step();
      end
      #1;
      check("mul_rst_cnt", bus.stall_cnt, 32'(exp_cnt));
      check("mul_rst_idle", 32'(bus.mc_busy), 32'd0);

      // Saturation on the 4-bit counter instance.
      bus4.load_e = 1'b1; bus4.rd_e = 5'd1; bus4.rs1_d = 5'd1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) check("sat_14", 32'(bus4.stall_cnt), 32'd14);
      end
      check("sat_hold", 32'(bus4.stall_cnt), 32'd15);
      clear_inputs4();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Next-generation hazard block for the 5-stage RV32 pipeline. It keeps the register-address-parametrised EX-stage operand forwarding and adds three things:
- load-use stall detection
- taken-branch flush generation
- a multi-cycle execute-op (MUL/DIV) interlock FSM

It also keeps a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their stall/flush enables.

Parameters:
REG_ADDR_W, 5, register-index width (x0 is always index 0)
MC_LAT, 4, execute-stage occupancy in cycles of a multi-cycle op; legal range 2..16
CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  pipeline clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
RegWriteM  input  1  M-stage instruction writes rd
RegWriteW  input  1  W-stage instruction writes rd
RD_E  input  REG_ADDR_W  E-stage destination
RD_M  input  REG_ADDR_W  M-stage destination
RD_W  input  REG_ADDR_W  W-stage destination
Rs1_D  input  REG_ADDR_W  D-stage source 1
Rs2_D  input  REG_ADDR_W  D-stage source 2
Rs1_E  input  REG_ADDR_W  E-stage source 1
Rs2_E  input  REG_ADDR_W  E-stage source 2
LoadE  input  1  E-stage instruction is a load
PCSrcE  input  1  taken branch/jump resolved in E
MulStartE  input  1  E-stage instruction is a multi-cycle op
ForwardAE  output  2  00 regfile, 10 from M, 01 from W
ForwardBE  output  2  same encoding for operand B
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  clear EX/MEM register (bubble)
McBusy  output  1  multi-cycle FSM not IDLE
StallCnt  output  CNT_W  cycles with StallF high, saturating

Behaviour:
- Reset state: while rst=0, every output is 0 and ForwardAE/BE=00. FSM=IDLE, cnt=0, StallCnt=0, applied asynchronously. Reset asserted mid multi-cycle op abandons it; the op restarts from IDLE after release.
- Forwarding is combinational.
  - ForwardAE=10 if RegWriteM & RD_M!=0 & RD_M==Rs1_E.
  - Else 01 if RegWriteW & RD_W!=0 & RD_W==Rs1_E.
  - Else 00.
  - ForwardBE is identical using Rs2_E.
  - M has priority over W.
- Load-use: lwStall = LoadE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D). A single-cycle stall: StallF, StallD and FlushE asserted.
- Branch: PCSrcE asserts FlushD and FlushE. PCSrcE, LoadE and MulStartE describe one E instruction and are mutually exclusive. If PCSrcE and MulStartE are both high, PCSrcE wins and MulStartE is ignored.
- Multi-cycle FSM has states IDLE and BUSY, with a 4-bit down-counter cnt.
  - IDLE & MulStartE & !PCSrcE: mcStall=1 this cycle; next state BUSY, cnt=MC_LAT-2.
  - BUSY & cnt!=0: mcStall=1, cnt decrements.
  - BUSY & cnt==0: mcStall=0, so the op leaves E at this edge; next state IDLE.
  - Resulting timing: E occupancy is exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
  - Back-to-back multi-cycle ops: the next MulStartE is sampled in the following IDLE cycle; no idle gap is required.
  - MulStartE is ignored while in BUSY.
- mcStall asserts StallF, StallD, StallE and FlushM.
- McBusy = (state==BUSY).
- Combination rules:
  - StallF = StallD = lwStall | mcStall
  - StallE = mcStall
  - FlushD = PCSrcE
  - FlushE = PCSrcE | (lwStall & !mcStall)
  - FlushM = mcStall
- StallCnt increments by 1 on each rising edge where StallF=1. It holds at all-ones; no wrap.
- No combinational path from any output back to an input inside the block. Outputs are registered-state plus combinational decode only.

Decomposition:
- Shared package (riscv_pkg): FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; mc_state_t enum {MC_IDLE, MC_BUSY}; REG_ADDR_W default.
- One sub-module: mc_interlock (FSM, cnt, mcStall, McBusy).
- Forwarding, load-use, flush logic and StallCnt stay in the top module.

Test Plan:
- Forward priority:
  - RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - RD_M=RD_W=0, Rs1_E=0 -> ForwardAE=00.
- Load-use: LoadE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle, StallCnt +1. Same with RD_E=0 -> no stall.
- Branch: PCSrcE=1 -> FlushD=FlushE=1, no stalls. PCSrcE=1 with MulStartE=1 -> FSM stays IDLE.
- Multi-cycle, MC_LAT=4: MulStartE held high -> StallF/D/E and FlushM high for 3 cycles, McBusy high for 3 cycles (set from cycle 2). The op leaves E on the 4th edge. A second MulStartE immediately after -> another 3 stall cycles; StallCnt=6.
- Reset: assert rst=0 during BUSY (cnt=1) -> outputs 0 and McBusy=0 immediately, before any clock edge. StallCnt=0. After release, MulStartE=1 -> full 3-cycle stall again.
- Saturation: with CNT_W=4, hold a stall for 20 cycles -> StallCnt reaches 15 and stays at 15.
